// File: rtl/rpm_gate_controller.sv
// rpm_gate_controller
// Windowed RPM measurement for the motor pole-change pulse train.
// Input path: 2-FF synchroniser, then a debounce filter. Rising edges of the
// filtered level are counted over back-to-back gate windows. Each closed window's
// count goes to a serial restoring divider, and the result is published over a
// valid/ready handshake.
//
// Handshake: rpm_valid means rpm holds a result nobody has taken yet. A
// transfer happens on any rising edge where rpm_valid && rpm_ready. A new
// result always replaces rpm and keeps rpm_valid high. If the old result was
// not taken on that same edge, the sticky overrun flag is set.
module rpm_gate_controller #(
    parameter int GATE_CYCLES     = 50000000,
    parameter int PULSES_PER_REV  = 80,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STALL_GATES     = 3
) (
    input  logic        clk50M,
    input  logic        reset,
    input  logic        enable,
    input  logic        blips,
    output logic [15:0] rpm,
    output logic        rpm_valid,
    input  logic        rpm_ready,
    output logic [7:0]  rpmPhone,
    output logic        stalled,
    output logic        overrun,
    output logic        busy,
    output logic        dbg_gate_state,
    output logic [1:0]  dbg_calc_state
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [7:0]    DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [12:0]   DIVISOR   = 13'(PULSES_PER_REV);
    localparam logic [3:0]    STALL_LIM = 4'(STALL_GATES);
    localparam logic [4:0]    DIV_LAST  = 5'd21;

    typedef enum logic {
        G_IDLE = 1'b0,
        G_GATE = 1'b1
    } gate_state_t;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_CALC = 2'd1,
        C_PUB  = 2'd2
    } calc_state_t;

    // ---------------- state and datapath registers ----------------
    logic [1:0]  sync_q, sync_d;
    logic        filt_q, filt_d;
    logic [7:0]  deb_cnt_q, deb_cnt_d;

    gate_state_t gate_state_q, gate_state_d;
    logic [GW-1:0] gate_cnt_q, gate_cnt_d;
    logic [15:0] edge_cnt_q, edge_cnt_d;
    logic [15:0] calc_in_q, calc_in_d;
    logic        calc_start_q, calc_start_d;
    logic [3:0]  zero_cnt_q, zero_cnt_d;

    calc_state_t calc_state_q, calc_state_d;
    logic [21:0] dvd_q, dvd_d;
    logic [12:0] rem_q, rem_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;

    logic [15:0] rpm_q, rpm_d;
    logic [7:0]  phone_q, phone_d;
    logic        valid_q, valid_d;
    logic        overrun_q, overrun_d;

    // ---------------- combinational helpers ----------------
    logic        rise;
    logic [15:0] edge_sum;
    logic        gate_active;
    logic        window_last;
    logic        window_close;
    logic        window_abandon;
    logic [21:0] prod;
    logic [12:0] rem_shift;
    logic [12:0] rem_sub;
    logic        q_bit;
    logic        calc_busy;
    logic        calc_pub;
    logic [15:0] quot_sat;
    logic [7:0]  phone_sat;

    // Synchroniser and debounce filter: filtered level follows the synchronised
    // input only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
    always_comb begin
        sync_d    = {sync_q[0], blips};
        filt_d    = filt_q;
        deb_cnt_d = '0;
        if (sync_q[1] != filt_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                filt_d = sync_q[1];
            end else begin
                deb_cnt_d = deb_cnt_q + 8'd1;
            end
        end
    end

    assign rise     = filt_d & ~filt_q;
    assign edge_sum = (rise && (edge_cnt_q != 16'hFFFF)) ? edge_cnt_q + 16'd1 : edge_cnt_q;

    // Input path registers.
    always_ff @(posedge clk50M) begin
        if (reset) begin
            sync_q    <= '0;
            filt_q    <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync_q    <= sync_d;
            filt_q    <= filt_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Gate FSM state register.
    always_ff @(posedge clk50M) begin
        if (reset) begin
            gate_state_q <= G_IDLE;
        end else begin
            gate_state_q <= gate_state_d;
        end
    end

    // Gate FSM next state: windows run back to back while enable stays high.
    always_comb begin
        gate_state_d = gate_state_q;
        case (gate_state_q)
            G_IDLE:  if (enable) gate_state_d = G_GATE;
            G_GATE:  if (!enable) gate_state_d = G_IDLE;
            default: gate_state_d = G_IDLE;
        endcase
    end

    // Gate FSM outputs: window close and abandon strobes.
    always_comb begin
        gate_active    = (gate_state_q == G_GATE);
        window_last    = (gate_cnt_q == GATE_LAST);
        window_close   = gate_active && enable && window_last;
        window_abandon = gate_active && !enable;
    end

    // Window datapath: count edges, and on close hand the count to the divider
    // and update the zero-window run length used for stall detection.
    always_comb begin
        gate_cnt_d   = gate_cnt_q;
        edge_cnt_d   = edge_cnt_q;
        calc_in_d    = calc_in_q;
        calc_start_d = 1'b0;
        zero_cnt_d   = zero_cnt_q;
        if (!gate_active || window_abandon) begin
            gate_cnt_d = '0;
            edge_cnt_d = '0;
        end else if (window_close) begin
            gate_cnt_d   = '0;
            edge_cnt_d   = '0;
            calc_in_d    = edge_sum;
            calc_start_d = 1'b1;
            if (edge_sum == 16'd0) begin
                if (zero_cnt_q != STALL_LIM) zero_cnt_d = zero_cnt_q + 4'd1;
            end else begin
                zero_cnt_d = '0;
            end
        end else begin
            gate_cnt_d = gate_cnt_q + 1'b1;
            edge_cnt_d = edge_sum;
        end
    end

    // Window datapath registers.
    always_ff @(posedge clk50M) begin
        if (reset) begin
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            calc_in_q    <= '0;
            calc_start_q <= 1'b0;
            zero_cnt_q   <= '0;
        end else begin
            gate_cnt_q   <= gate_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            calc_in_q    <= calc_in_d;
            calc_start_q <= calc_start_d;
            zero_cnt_q   <= zero_cnt_d;
        end
    end

    // Calc FSM state register.
    always_ff @(posedge clk50M) begin
        if (reset) begin
            calc_state_q <= C_IDLE;
        end else begin
            calc_state_q <= calc_state_d;
        end
    end

    // Calc FSM next state: load, 22 divide steps, one publish cycle.
    always_comb begin
        calc_state_d = calc_state_q;
        case (calc_state_q)
            C_IDLE:  if (calc_start_q) calc_state_d = C_CALC;
            C_CALC:  if (bit_cnt_q == DIV_LAST) calc_state_d = C_PUB;
            C_PUB:   calc_state_d = C_IDLE;
            default: calc_state_d = C_IDLE;
        endcase
    end

    // Calc FSM outputs.
    always_comb begin
        calc_busy = (calc_state_q == C_CALC);
        calc_pub  = (calc_state_q == C_PUB);
    end

    // Restoring divider step. rem_q is always below the divisor, so its low 12 bits
    // hold it fully. The quotient shifts into dvd_q as the dividend shifts out.
    assign prod      = 22'(calc_in_q) * 22'd60;
    assign rem_shift = {rem_q[11:0], dvd_q[21]};
    assign rem_sub   = rem_shift - DIVISOR;
    assign q_bit     = (rem_shift >= DIVISOR);

    // Divider datapath.
    always_comb begin
        dvd_d     = dvd_q;
        rem_d     = rem_q;
        bit_cnt_d = bit_cnt_q;
        case (calc_state_q)
            C_IDLE: begin
                if (calc_start_q) begin
                    dvd_d     = prod;
                    rem_d     = '0;
                    bit_cnt_d = '0;
                end
            end
            C_CALC: begin
                dvd_d     = {dvd_q[20:0], q_bit};
                rem_d     = q_bit ? rem_sub : rem_shift;
                bit_cnt_d = bit_cnt_q + 5'd1;
            end
            default: begin
                bit_cnt_d = bit_cnt_q;
            end
        endcase
    end

    // Divider registers.
    always_ff @(posedge clk50M) begin
        if (reset) begin
            dvd_q     <= '0;
            rem_q     <= '0;
            bit_cnt_q <= '0;
        end else begin
            dvd_q     <= dvd_d;
            rem_q     <= rem_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign quot_sat  = (dvd_q[21:16] != 6'd0) ? 16'hFFFF : dvd_q[15:0];
    assign phone_sat = (quot_sat[15:9] != 7'd0) ? 8'hFF : quot_sat[8:1];

    // Result publication and handshake bookkeeping.
    always_comb begin
        rpm_d     = rpm_q;
        phone_d   = phone_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (valid_q && rpm_ready) valid_d = 1'b0;
        if (calc_pub) begin
            rpm_d   = quot_sat;
            phone_d = phone_sat;
            valid_d = 1'b1;
            if (valid_q && !rpm_ready) overrun_d = 1'b1;
        end
    end

    // Published result registers.
    always_ff @(posedge clk50M) begin
        if (reset) begin
            rpm_q     <= '0;
            phone_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            rpm_q     <= rpm_d;
            phone_q   <= phone_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign rpm            = rpm_q;
    assign rpmPhone       = phone_q;
    assign rpm_valid      = valid_q;
    assign overrun        = overrun_q;
    assign stalled        = (zero_cnt_q == STALL_LIM);
    assign busy           = calc_busy;
    assign dbg_gate_state = gate_state_q;
    assign dbg_calc_state = calc_state_q;

endmodule

// File: tb/tb_rpm_gate_controller.sv
// Directed bench for rpm_gate_controller.
// Instance a: 200-cycle windows, PPR 80, debounce 2, stall after 3 zero windows.
// Instance b: 2400-cycle windows, PPR 1, debounce 1, used for saturation.
module tb_rpm_gate_controller;

    localparam int A_GATE = 200;
    localparam int B_GATE = 2400;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        blips = 1'b0;
    logic        rpm_ready = 1'b1;

    logic [15:0] rpm_a, rpm_b;
    logic        rpm_valid_a, rpm_valid_b;
    logic [7:0]  phone_a, phone_b;
    logic        stalled_a, stalled_b;
    logic        overrun_a, overrun_b;
    logic        busy_a, busy_b;
    logic        gst_a, gst_b;
    logic [1:0]  cst_a, cst_b;

    int checks = 0;
    int errors = 0;

    rpm_gate_controller #(
        .GATE_CYCLES(A_GATE), .PULSES_PER_REV(80), .DEBOUNCE_CYCLES(2), .STALL_GATES(3)
    ) u_a (
        .clk50M(clk), .reset(reset), .enable(enable), .blips(blips),
        .rpm(rpm_a), .rpm_valid(rpm_valid_a), .rpm_ready(rpm_ready),
        .rpmPhone(phone_a), .stalled(stalled_a), .overrun(overrun_a), .busy(busy_a),
        .dbg_gate_state(gst_a), .dbg_calc_state(cst_a)
    );

    rpm_gate_controller #(
        .GATE_CYCLES(B_GATE), .PULSES_PER_REV(1), .DEBOUNCE_CYCLES(1), .STALL_GATES(1)
    ) u_b (
        .clk50M(clk), .reset(reset), .enable(enable), .blips(blips),
        .rpm(rpm_b), .rpm_valid(rpm_valid_b), .rpm_ready(rpm_ready),
        .rpmPhone(phone_b), .stalled(stalled_b), .overrun(overrun_b), .busy(busy_b),
        .dbg_gate_state(gst_b), .dbg_calc_state(cst_b)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, then enable: returns just after the edge that starts window 0.
    task automatic start_run();
        reset  = 1'b1;
        enable = 1'b0;
        blips  = 1'b0;
        repeat (3) tick();
        reset  = 1'b0;
        enable = 1'b1;
        tick();
    endtask

    // One instance-a window: 30 idle cycles (skip already spent by caller),
    // n pulses of hi/lo cycles, idle to the closing edge.
    task automatic window_a(input int n, input int hi, input int lo, input int skip);
        int used;
        repeat (30 - skip) tick();
        for (int i = 0; i < n; i++) begin
            blips = 1'b1;
            repeat (hi) tick();
            blips = 1'b0;
            repeat (lo) tick();
        end
        used = 30 + n * (hi + lo);
        repeat (A_GATE - used) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({rpm_a, phone_a, rpm_valid_a, stalled_a, overrun_a, busy_a} !== 30'd0) begin
            errors++;
            $display("FAIL reset_a got rpm=%0h ph=%0h v=%0b st=%0b ov=%0b bz=%0b exp all 0",
                     rpm_a, phone_a, rpm_valid_a, stalled_a, overrun_a, busy_a);
        end
        checks++;
        if ({rpm_b, phone_b, rpm_valid_b, stalled_b, overrun_b, busy_b} !== 30'd0) begin
            errors++;
            $display("FAIL reset_b got rpm=%0h ph=%0h v=%0b st=%0b ov=%0b bz=%0b exp all 0",
                     rpm_b, phone_b, rpm_valid_b, stalled_b, overrun_b, busy_b);
        end
        checks++;
        if ({gst_a, cst_a} !== 3'd0) begin
            errors++;
            $display("FAIL reset_fsm got gate=%0d calc=%0d exp 0 0", gst_a, cst_a);
        end
    endtask

    task automatic test_basic();
        start_run();
        rpm_ready = 1'b1;
        window_a(40, 2, 2, 0);
        repeat (23) tick();
        checks++;
        if (rpm_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got valid=%0b exp 0", rpm_valid_a);
        end
        tick();
        checks++;
        if (rpm_valid_a !== 1'b1 || rpm_a !== 16'd30 || phone_a !== 8'd15) begin
            errors++;
            $display("FAIL basic_40 got v=%0b rpm=%0d ph=%0d exp v=1 rpm=30 ph=15",
                     rpm_valid_a, rpm_a, phone_a);
        end
        window_a(8, 2, 2, 24);
        repeat (24) tick();
        checks++;
        if (rpm_valid_a !== 1'b1 || rpm_a !== 16'd6 || phone_a !== 8'd3) begin
            errors++;
            $display("FAIL basic_8 got v=%0b rpm=%0d ph=%0d exp v=1 rpm=6 ph=3",
                     rpm_valid_a, rpm_a, phone_a);
        end
        window_a(20, 2, 2, 24);
        repeat (24) tick();
        checks++;
        if (rpm_a !== 16'd15 || phone_a !== 8'd7) begin
            errors++;
            $display("FAIL basic_20 got rpm=%0d ph=%0d exp rpm=15 ph=7", rpm_a, phone_a);
        end
        window_a(0, 2, 2, 24);
        repeat (24) tick();
        checks++;
        if (rpm_valid_a !== 1'b1 || rpm_a !== 16'd0) begin
            errors++;
            $display("FAIL basic_0 got v=%0b rpm=%0d exp v=1 rpm=0", rpm_valid_a, rpm_a);
        end
    endtask

    task automatic test_glitch_filter();
        start_run();
        rpm_ready = 1'b1;
        window_a(8, 2, 2, 0);
        repeat (24) tick();
        checks++;
        if (rpm_a !== 16'd6) begin
            errors++;
            $display("FAIL glitch_pre got rpm=%0d exp 6", rpm_a);
        end
        window_a(5, 1, 5, 24);
        repeat (24) tick();
        checks++;
        if (rpm_valid_a !== 1'b1 || rpm_a !== 16'd0) begin
            errors++;
            $display("FAIL glitch_reject got v=%0b rpm=%0d exp v=1 rpm=0", rpm_valid_a, rpm_a);
        end
        window_a(10, 6, 6, 24);
        repeat (24) tick();
        checks++;
        if (rpm_a !== 16'd7 || phone_a !== 8'd3) begin
            errors++;
            $display("FAIL glitch_slow10 got rpm=%0d ph=%0d exp rpm=7 ph=3", rpm_a, phone_a);
        end
    endtask

    task automatic test_handshake();
        start_run();
        rpm_ready = 1'b0;
        window_a(8, 2, 2, 0);
        repeat (24) tick();
        checks++;
        if (rpm_valid_a !== 1'b1 || rpm_a !== 16'd6 || overrun_a !== 1'b0) begin
            errors++;
            $display("FAIL hs_first got v=%0b rpm=%0d ov=%0b exp v=1 rpm=6 ov=0",
                     rpm_valid_a, rpm_a, overrun_a);
        end
        window_a(20, 2, 2, 24);
        repeat (24) tick();
        checks++;
        if (rpm_valid_a !== 1'b1 || rpm_a !== 16'd15 || overrun_a !== 1'b1) begin
            errors++;
            $display("FAIL hs_overwrite got v=%0b rpm=%0d ov=%0b exp v=1 rpm=15 ov=1",
                     rpm_valid_a, rpm_a, overrun_a);
        end
        window_a(40, 2, 2, 24);
        repeat (23) tick();
        rpm_ready = 1'b1;
        tick();
        checks++;
        if (rpm_valid_a !== 1'b1 || rpm_a !== 16'd30 || overrun_a !== 1'b1) begin
            errors++;
            $display("FAIL hs_ack_on_pub got v=%0b rpm=%0d ov=%0b exp v=1 rpm=30 ov=1",
                     rpm_valid_a, rpm_a, overrun_a);
        end
        tick();
        checks++;
        if (rpm_valid_a !== 1'b0 || overrun_a !== 1'b1) begin
            errors++;
            $display("FAIL hs_ack_clear got v=%0b ov=%0b exp v=0 ov=1", rpm_valid_a, overrun_a);
        end
    endtask

    task automatic test_stall();
        start_run();
        rpm_ready = 1'b1;
        window_a(0, 2, 2, 0);
        window_a(0, 2, 2, 0);
        checks++;
        if (stalled_a !== 1'b0) begin
            errors++;
            $display("FAIL stall_two got %0b exp 0", stalled_a);
        end
        window_a(0, 2, 2, 0);
        checks++;
        if (stalled_a !== 1'b1) begin
            errors++;
            $display("FAIL stall_three got %0b exp 1", stalled_a);
        end
        repeat (24) tick();
        checks++;
        if (rpm_valid_a !== 1'b1 || rpm_a !== 16'd0) begin
            errors++;
            $display("FAIL stall_pub_zero got v=%0b rpm=%0d exp v=1 rpm=0", rpm_valid_a, rpm_a);
        end
        window_a(8, 2, 2, 24);
        checks++;
        if (stalled_a !== 1'b0) begin
            errors++;
            $display("FAIL stall_clear got %0b exp 0", stalled_a);
        end
        repeat (24) tick();
        checks++;
        if (rpm_a !== 16'd6) begin
            errors++;
            $display("FAIL stall_rpm got %0d exp 6", rpm_a);
        end
    endtask

    task automatic test_saturation();
        start_run();
        rpm_ready = 1'b1;
        repeat (20) tick();
        for (int i = 0; i < 2300; i++) begin
            blips = ~blips;
            tick();
        end
        blips = 1'b0;
        repeat (B_GATE - 2320) tick();
        repeat (24) tick();
        checks++;
        if (rpm_b !== 16'hFFFF || phone_b !== 8'd255) begin
            errors++;
            $display("FAIL sat_high got rpm=%0h ph=%0d exp rpm=ffff ph=255", rpm_b, phone_b);
        end
        repeat (6) tick();
        for (int i = 0; i < 2; i++) begin
            blips = 1'b1;
            repeat (2) tick();
            blips = 1'b0;
            repeat (2) tick();
        end
        repeat (B_GATE - 24 - 6 - 8) tick();
        repeat (24) tick();
        checks++;
        if (rpm_b !== 16'd120 || phone_b !== 8'd60) begin
            errors++;
            $display("FAIL sat_small got rpm=%0d ph=%0d exp rpm=120 ph=60", rpm_b, phone_b);
        end
    endtask

    task automatic test_enable_drop_and_reset();
        int seen;
        start_run();
        rpm_ready = 1'b1;
        window_a(8, 2, 2, 0);
        repeat (5) tick();
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL drop_busy got %0b exp 1", busy_a);
        end
        for (int i = 0; i < 4; i++) begin
            blips = 1'b1;
            repeat (2) tick();
            blips = 1'b0;
            repeat (2) tick();
        end
        enable = 1'b0;
        repeat (3) tick();
        checks++;
        if (rpm_valid_a !== 1'b1 || rpm_a !== 16'd6) begin
            errors++;
            $display("FAIL drop_inflight_pub got v=%0b rpm=%0d exp v=1 rpm=6", rpm_valid_a, rpm_a);
        end
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (rpm_valid_a) seen++;
        end
        checks++;
        if (seen !== 0 || rpm_a !== 16'd6 || gst_a !== 1'b0) begin
            errors++;
            $display("FAIL drop_abandoned got pubs=%0d rpm=%0d gate=%0b exp 0 6 0", seen, rpm_a, gst_a);
        end
        enable = 1'b1;
        tick();
        window_a(10, 2, 2, 0);
        repeat (10) tick();
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL rst_busy_before got %0b exp 1", busy_a);
        end
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        checks++;
        if ({rpm_a, phone_a, rpm_valid_a, stalled_a, overrun_a, busy_a} !== 30'd0) begin
            errors++;
            $display("FAIL rst_mid_calc got rpm=%0h ph=%0h v=%0b st=%0b ov=%0b bz=%0b exp all 0",
                     rpm_a, phone_a, rpm_valid_a, stalled_a, overrun_a, busy_a);
        end
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rpm_valid_a || busy_a) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rst_discard got active_cycles=%0d exp 0", seen);
        end
    endtask

    // Test sequence and summary.
    initial begin
        test_reset();
        test_basic();
        test_glitch_filter();
        test_handshake();
        test_stall();
        test_saturation();
        test_enable_drop_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
